// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction memory with sequential loader and LOAD/RUN/HALT fetch FSM
// Optional address range checking is enabled by defining IFETCH_RANGE_CHECK_EN.
module instr_fetch #(
    parameter logic [31:0] BASE     = 32'h0000_3000,
    parameter int          IM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    input  logic        load_last,
    output logic        load_ready,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        hold,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fetch_count
);
    localparam int              AW       = $clog2(IM_WORDS);
    localparam logic [AW-1:0]   LAST_PTR = AW'(IM_WORDS - 1);
    localparam logic [31:0]     SYSCALL  = 32'h0000_000C;

    typedef enum logic [1:0] {S_LOAD, S_RUN, S_HALT} state_t;

    state_t        r_state;
    logic [AW-1:0] r_ptr;
    logic [31:0]   r_mem [IM_WORDS];
    logic [31:0]   r_fetch_count;
    logic          r_load_ready;
    logic          r_hold;
    logic          r_halted;
    logic          r_fault;

    logic [AW-1:0] w_index;
    logic          w_bad;
    logic          w_fetch;
    logic          w_syscall;
    logic          w_load_fire;
    logic [31:0]   w_instr;

    // Out-of-range addresses alias into memory when no range check is built in.
    assign w_index = AW'((PC - BASE) >> 2);

`ifdef IFETCH_RANGE_CHECK_EN
    localparam logic [31:0] LIMIT = BASE + 32'(4 * IM_WORDS);
    assign w_bad = (r_state == S_RUN) &&
                   ((PC[1:0] != 2'b00) || (PC < BASE) || (PC >= LIMIT));
`else
    assign w_bad = 1'b0;
`endif

    assign w_fetch     = (r_state == S_RUN) && !w_bad;
    assign w_instr     = w_fetch ? r_mem[w_index] : 32'h0;
    assign w_syscall   = w_fetch && (w_instr == SYSCALL);
    assign w_load_fire = (r_state == S_LOAD) && load_valid && !reset;

    // Memory is deliberately left out of reset so reloads can be partial.
    always_ff @(posedge clk) begin
        if (w_load_fire) begin
            r_mem[r_ptr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_LOAD;
            r_ptr         <= '0;
            r_fetch_count <= 32'h0;
            r_load_ready  <= 1'b1;
            r_hold        <= 1'b1;
            r_halted      <= 1'b0;
            r_fault       <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (load_valid) begin
                        if (load_last || (r_ptr == LAST_PTR)) begin
                            r_state      <= S_RUN;
                            r_load_ready <= 1'b0;
                            r_hold       <= 1'b0;
                        end else begin
                            r_ptr <= r_ptr + 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (w_fetch) begin
                        r_fetch_count <= r_fetch_count + 32'h1;
                    end
                    if (w_bad || w_syscall) begin
                        r_state  <= S_HALT;
                        r_hold   <= 1'b1;
                        r_halted <= 1'b1;
                        r_fault  <= w_bad;
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_LOAD;
                end
            endcase
        end
    end

    assign load_ready  = r_load_ready;
    assign instr       = w_instr;
    assign instr_valid = w_fetch;
    assign hold        = r_hold;
    assign halted      = r_halted;
    assign fault       = r_fault;
    assign fetch_count = r_fetch_count;

endmodule
